// File: rtl/seg7_scan_capture_pkg.sv
// Shared definitions for the seven-segment scan reader: glyph table, blank anode
// pattern, FSM encodings and the anode one-hot decoder.
package seg7_scan_capture_pkg;

    // Active-low cathodes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    localparam logic [3:0] AN_BLANK = 4'b1111;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

    // Complete FSM state, kept as one struct so a checker can bind to it directly.
    typedef struct packed {
        state_t     state;
        logic [1:0] exp_idx;
    } fsm_t;

    // Returns {one_hot, idx}; one_hot is 0 for blank or multi-digit anode patterns.
    function automatic logic [2:0] an_decode(input logic [3:0] an);
        case (an)
            4'b1110: an_decode = {1'b1, 2'd0};
            4'b1101: an_decode = {1'b1, 2'd1};
            4'b1011: an_decode = {1'b1, 2'd2};
            4'b0111: an_decode = {1'b1, 2'd3};
            default: an_decode = {1'b0, 2'd0};
        endcase
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the hex glyph encoder: segment pattern back to a nibble.
module seg7_to_hex
    import seg7_scan_capture_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] nibble
);

    always_comb begin
        legal  = 1'b1;
        nibble = 4'h0;
        case (seg)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed 4-digit seven-segment bus, decodes each settled dwell and
// reassembles in-order frames into a 16-bit value, flagging decode/order/timeout errors.
module seg7_scan_capture
    import seg7_scan_capture_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 65536,
    parameter int TO_W    = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic        stable,
    output logic        err_pattern,
    output logic        err_order,
    output logic        err_timeout
);

    localparam int              CNT_W   = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

    logic [10:0]      sync1_q, sync2_q, last_cap_q;
    logic [CNT_W-1:0] settle_q;
    logic [15:0]      asm_q;
    logic [TO_W-1:0]  to_q;
    logic             have_prev_q;
    fsm_t             fsm_q;

    logic       capture, cap_digit, an_one_hot, glyph_legal;
    logic       bad_anode, bad_pattern, good_cap;
    logic [1:0] an_idx;
    logic [3:0] glyph_nib;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            settle_q <= '0;
        end else begin
            sync1_q <= {an, seg};
            sync2_q <= sync1_q;
            if (sync1_q != sync2_q)
                settle_q <= '0;
            else if (settle_q != CNT_MAX)
                settle_q <= settle_q + 1'b1;
        end
    end

    // A glitch shorter than SETTLE restarts the count; the last_cap_q compare stops
    // the same dwell from being captured a second time once it resettles.
    assign capture   = (settle_q == CNT_CAP) && (sync2_q != last_cap_q);
    assign cap_digit = capture && (sync2_q[10:7] != AN_BLANK);
    assign {an_one_hot, an_idx} = an_decode(sync2_q[10:7]);

    seg7_to_hex u_to_hex (
        .seg    (sync2_q[6:0]),
        .legal  (glyph_legal),
        .nibble (glyph_nib)
    );

    assign bad_anode   = cap_digit && !an_one_hot;
    assign bad_pattern = cap_digit && an_one_hot && !glyph_legal;
    assign good_cap    = cap_digit && an_one_hot && glyph_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= '{state: ST_SYNC, exp_idx: 2'd0};
            last_cap_q  <= '1;
            asm_q       <= '0;
            to_q        <= '0;
            have_prev_q <= 1'b0;
            value       <= '0;
            frame_valid <= 1'b0;
            stable      <= 1'b0;
            err_pattern <= 1'b0;
            err_order   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            err_pattern <= 1'b0;
            err_order   <= 1'b0;
            err_timeout <= 1'b0;
            if (capture)
                last_cap_q <= sync2_q;
            if (fsm_q.state == ST_COLLECT)
                to_q <= to_q + 1'b1;

            if (bad_anode) begin
                err_order   <= 1'b1;
                stable      <= 1'b0;
                fsm_q.state <= ST_SYNC;
            end else if (bad_pattern) begin
                err_pattern <= 1'b1;
                stable      <= 1'b0;
                fsm_q.state <= ST_SYNC;
            end else begin
                case (fsm_q.state)
                    ST_SYNC: begin
                        if (good_cap && an_idx == 2'd0) begin
                            asm_q[3:0]    <= glyph_nib;
                            fsm_q.exp_idx <= 2'd1;
                            to_q          <= '0;
                            fsm_q.state   <= ST_COLLECT;
                        end
                    end
                    ST_COLLECT: begin
                        if (good_cap) begin
                            if (an_idx == fsm_q.exp_idx) begin
                                asm_q[{an_idx, 2'b00} +: 4] <= glyph_nib;
                                fsm_q.exp_idx <= fsm_q.exp_idx + 2'd1;
                                to_q          <= '0;
                                if (an_idx == 2'd3)
                                    fsm_q.state <= ST_EMIT;
                            end else if (an_idx == 2'd0) begin
                                // Display restarted its scan: begin a fresh frame quietly.
                                asm_q[3:0]    <= glyph_nib;
                                fsm_q.exp_idx <= 2'd1;
                                to_q          <= '0;
                            end else begin
                                err_order   <= 1'b1;
                                stable      <= 1'b0;
                                fsm_q.state <= ST_SYNC;
                            end
                        end else if (to_q == TO_LAST) begin
                            err_timeout <= 1'b1;
                            stable      <= 1'b0;
                            fsm_q.state <= ST_SYNC;
                        end
                    end
                    ST_EMIT: begin
                        value       <= asm_q;
                        frame_valid <= 1'b1;
                        stable      <= have_prev_q && (asm_q == value);
                        have_prev_q <= 1'b1;
                        fsm_q.state <= ST_SYNC;
                    end
                    default: fsm_q.state <= ST_SYNC;
                endcase
            end
        end
    end

endmodule
